// File: rtl/cva6_hpdcache_req_arbiter.sv
// Round-robin arbiter sharing the HPDcache request port among NumReq requesters; store credits and sid response routing.
// Latency: zero-cycle request pass-through and zero-cycle response demux; the grant is locked until its handshake.
// Backpressure: cache_req_ready_i low holds the winner; stores stall at MaxOutstandingStores credits; drain_i blocks new grants.
module cva6_hpdcache_req_arbiter #(
    parameter int NumReq               = 4,
    parameter int PayloadWidth         = 128,
    parameter int MaxOutstandingStores = 7,
    parameter int SidWidth             = $clog2(NumReq),
    parameter int CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0]                req_store_i,
    input  logic [NumReq*PayloadWidth-1:0]   req_payload_i,
    output logic                             cache_req_valid_o,
    input  logic                             cache_req_ready_i,
    output logic [PayloadWidth-1:0]          cache_req_payload_o,
    output logic [SidWidth-1:0]              cache_req_sid_o,
    output logic                             cache_req_store_o,
    input  logic                             cache_rsp_valid_i,
    input  logic [SidWidth-1:0]              cache_rsp_sid_i,
    input  logic                             cache_rsp_store_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    input  logic                             drain_i,
    output logic                             idle_o,
    output logic [CntWidth-1:0]              store_cnt_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [SidWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [SidWidth-1:0] lock_q, lock_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic [NumReq-1:0]   eligible;
    logic                credit_ok;
    logic                pick_vld;
    logic [SidWidth-1:0] pick_idx;
    logic [SidWidth-1:0] gnt_idx;
    logic [SidWidth-1:0] gnt_nxt;
    logic                hs;
    logic                cnt_inc;
    logic                cnt_dec;

    assign credit_ok = (cnt_q < CntWidth'(MaxOutstandingStores));
    assign eligible  = req_valid_i & (~req_store_i | {NumReq{credit_ok}});

    // Scan from the highest offset down so the closest eligible index to rr_ptr_q wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int off = NumReq - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr_q) + off) % NumReq;
            if (eligible[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx[SidWidth-1:0];
            end
        end
    end

    assign gnt_idx = (state_q == ST_HOLD) ? lock_q : pick_idx;
    assign gnt_nxt = (gnt_idx == SidWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;

    // Gated by rst_ni so an in-flight request disappears the moment reset asserts.
    assign cache_req_valid_o   = rst_ni & ((state_q == ST_HOLD) | (~drain_i & pick_vld));
    assign cache_req_payload_o = req_payload_i[gnt_idx*PayloadWidth +: PayloadWidth];
    assign cache_req_sid_o     = gnt_idx;
    assign cache_req_store_o   = req_store_i[gnt_idx];

    assign hs = cache_req_valid_o & cache_req_ready_i;

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = hs & (gnt_idx == SidWidth'(i));
            rsp_valid_o[i] = rst_ni & cache_rsp_valid_i & (cache_rsp_sid_i == SidWidth'(i));
        end
    end

    assign cnt_inc = hs & cache_req_store_o;
    assign cnt_dec = cache_rsp_valid_i & cache_rsp_store_i & (cnt_q != '0);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        cnt_d    = cnt_q;
        if (hs) begin
            rr_ptr_d = gnt_nxt;
        end
        case (state_q)
            ST_IDLE: begin
                if (cache_req_valid_o && !cache_req_ready_i) begin
                    state_d = ST_HOLD;
                    lock_d  = pick_idx;
                end
            end
            default: begin
                if (cache_req_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!cnt_inc && cnt_dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            lock_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
        end
    end

    assign idle_o      = (state_q == ST_IDLE) & (cnt_q == '0);
    assign store_cnt_o = cnt_q;

    a_hold_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ST_HOLD) |-> req_valid_i[lock_q]);
    a_no_dec_at_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cache_rsp_valid_i && cache_rsp_store_i) |-> (cnt_q != '0));
    a_rsp_sid_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cache_rsp_valid_i |-> (int'(cache_rsp_sid_i) < NumReq));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(cnt_q) <= MaxOutstandingStores);

endmodule

// File: tb/tb_cva6_hpdcache_req_arbiter.sv
// Scoreboard bench for cva6_hpdcache_req_arbiter: stimulus pushes expected grants, a negedge monitor pops and compares.
module tb_cva6_hpdcache_req_arbiter;

    localparam int NumReq = 4;
    localparam int PW     = 128;
    localparam int MaxSt  = 7;
    localparam int SidW   = 2;
    localparam int CntW   = 3;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [NumReq-1:0]  req_valid_i;
    logic [NumReq-1:0]  req_ready_o;
    logic [NumReq-1:0]  req_store_i;
    logic [NumReq*PW-1:0] req_payload_i;
    logic               cache_req_valid_o;
    logic               cache_req_ready_i;
    logic [PW-1:0]      cache_req_payload_o;
    logic [SidW-1:0]    cache_req_sid_o;
    logic               cache_req_store_o;
    logic               cache_rsp_valid_i;
    logic [SidW-1:0]    cache_rsp_sid_i;
    logic               cache_rsp_store_i;
    logic [NumReq-1:0]  rsp_valid_o;
    logic               drain_i;
    logic               idle_o;
    logic [CntW-1:0]    store_cnt_o;

    logic [PW-1:0]      pl [NumReq];

    always #5 clk_i = ~clk_i;

    always_comb begin
        req_payload_i = '0;
        for (int i = 0; i < NumReq; i++) req_payload_i[i*PW +: PW] = pl[i];
    end

    cva6_hpdcache_req_arbiter #(
        .NumReq(NumReq), .PayloadWidth(PW), .MaxOutstandingStores(MaxSt)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_store_i(req_store_i), .req_payload_i(req_payload_i),
        .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cache_req_ready_i),
        .cache_req_payload_o(cache_req_payload_o), .cache_req_sid_o(cache_req_sid_o),
        .cache_req_store_o(cache_req_store_o),
        .cache_rsp_valid_i(cache_rsp_valid_i), .cache_rsp_sid_i(cache_rsp_sid_i),
        .cache_rsp_store_i(cache_rsp_store_i), .rsp_valid_o(rsp_valid_o),
        .drain_i(drain_i), .idle_o(idle_o), .store_cnt_o(store_cnt_o)
    );

    typedef struct packed {
        logic [SidW-1:0] sid;
        logic            store;
        logic [PW-1:0]   pl;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int sid, input logic st);
        exp_t e;
        e.sid   = SidW'(sid);
        e.store = st;
        e.pl    = pl[sid];
        exp_q.push_back(e);
    endtask

    task automatic set_pl(input int tag);
        for (int i = 0; i < NumReq; i++)
            pl[i] = {32'(tag), 32'(i), 64'hDEAD_BEEF_0123_4567 ^ 64'(i * 17)};
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every handshake must match the oldest expected grant.
    initial begin
        exp_t e;
        logic [NumReq-1:0] oh;
        forever begin
            @(negedge clk_i);
            if (cache_req_valid_o && cache_req_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_hs_sid", {126'd0, cache_req_sid_o}, {PW{1'b1}});
                end else begin
                    e  = exp_q.pop_front();
                    oh = NumReq'(1) << e.sid;
                    chk("mon_sid", cache_req_sid_o, e.sid);
                    chk("mon_store", cache_req_store_o, e.store);
                    chk("mon_payload", cache_req_payload_o, e.pl);
                    chk("mon_req_ready", req_ready_o, oh);
                end
            end else begin
                chk("mon_ready_no_hs", req_ready_o, '0);
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        req_valid_i = '0; req_store_i = '0; cache_req_ready_i = 1'b0;
        cache_rsp_valid_i = 1'b0; cache_rsp_sid_i = '0; cache_rsp_store_i = 1'b0;
        drain_i = 1'b0;
        set_pl(0);
        #12;
        chk("rst_valid", cache_req_valid_o, 0);
        chk("rst_rsp", rsp_valid_o, 0);
        chk("rst_cnt", store_cnt_o, 0);
        chk("rst_idle", idle_o, 1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Alternating loads from req0/req1
        req_valid_i = 4'b0011; cache_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_pl(k + 1);
            push(k % 2, 1'b0);
            @(negedge clk_i);
            chk("t1_sid", cache_req_sid_o, k % 2);
            step();
        end
        req_valid_i = '0;

        // Grant locked on req2 while ready is low
        set_pl(10);
        req_valid_i = 4'b0100; cache_req_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) req_valid_i[0] = 1'b1;
            @(negedge clk_i);
            chk("t2_hold_valid", cache_req_valid_o, 1);
            chk("t2_hold_sid", cache_req_sid_o, 2);
            step();
        end
        cache_req_ready_i = 1'b1;
        push(2, 1'b0);
        @(negedge clk_i);
        step();
        req_valid_i[2] = 1'b0;
        push(0, 1'b0);
        @(negedge clk_i);
        chk("t2_after_sid", cache_req_sid_o, 0);
        step();
        req_valid_i = '0;

        // Store credit exhaustion on req1; loads from req0 still flow
        set_pl(20);
        req_valid_i = 4'b0010; req_store_i = 4'b0010;
        for (int k = 0; k < 7; k++) begin
            push(1, 1'b1);
            step();
        end
        chk("t3_cnt_full", store_cnt_o, 7);
        req_valid_i[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(0, 1'b0);
            @(negedge clk_i);
            chk("t3_store_blocked", req_ready_o[1], 0);
            chk("t3_load_sid", cache_req_sid_o, 0);
            step();
        end
        req_valid_i[0] = 1'b0;
        @(negedge clk_i);
        chk("t3_no_valid", cache_req_valid_o, 0);
        step();
        cache_rsp_valid_i = 1'b1; cache_rsp_sid_i = 2'd1; cache_rsp_store_i = 1'b1;
        @(negedge clk_i);
        chk("t3_rsp_demux", rsp_valid_o, 4'b0010);
        chk("t3_still_blocked", cache_req_valid_o, 0);
        step();
        cache_rsp_valid_i = 1'b0;
        chk("t3_cnt_after_rsp", store_cnt_o, 6);
        push(1, 1'b1);
        @(negedge clk_i);
        chk("t3_8th_store_sid", cache_req_sid_o, 1);
        step();
        req_valid_i = '0; req_store_i = '0;
        chk("t3_cnt_refull", store_cnt_o, 7);
        cache_rsp_valid_i = 1'b1;
        repeat (4) step();
        cache_rsp_valid_i = 1'b0;
        chk("t3_cnt_drained", store_cnt_o, 3);

        // Simultaneous store issue and store response
        req_valid_i = 4'b1000; req_store_i = 4'b1000;
        cache_rsp_valid_i = 1'b1; cache_rsp_sid_i = 2'd3; cache_rsp_store_i = 1'b1;
        push(3, 1'b1);
        @(negedge clk_i);
        chk("t4_rsp_demux", rsp_valid_o, 4'b1000);
        step();
        req_valid_i = '0; req_store_i = '0;
        chk("t4_cnt_same", store_cnt_o, 3);
        step();
        cache_rsp_valid_i = 1'b0;
        chk("t4_cnt_two", store_cnt_o, 2);

        // Drain blocks grants until released
        drain_i = 1'b1; req_valid_i = 4'b0001;
        @(negedge clk_i);
        chk("t5_drain_no_valid", cache_req_valid_o, 0);
        chk("t5_not_idle", idle_o, 0);
        step();
        cache_rsp_valid_i = 1'b1; cache_rsp_sid_i = 2'd0; cache_rsp_store_i = 1'b1;
        repeat (2) step();
        cache_rsp_valid_i = 1'b0;
        chk("t5_idle", idle_o, 1);
        chk("t5_cnt_zero", store_cnt_o, 0);
        @(negedge clk_i);
        chk("t5_still_drained", cache_req_valid_o, 0);
        step();
        drain_i = 1'b0;
        push(0, 1'b0);
        @(negedge clk_i);
        chk("t5_grant_valid", cache_req_valid_o, 1);
        chk("t5_grant_sid", cache_req_sid_o, 0);
        step();
        req_valid_i = '0;

        // Reset asserted mid-HOLD
        set_pl(30);
        req_valid_i = 4'b0100; req_store_i = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            push(2, 1'b1);
            step();
        end
        chk("t6_cnt_four", store_cnt_o, 4);
        cache_req_ready_i = 1'b0;
        @(negedge clk_i);
        chk("t6_hold_sid", cache_req_sid_o, 2);
        step();
        @(negedge clk_i);
        chk("t6_hold_not_idle", idle_o, 0);
        chk("t6_hold_valid", cache_req_valid_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", cache_req_valid_o, 0);
        chk("t6_rst_cnt", store_cnt_o, 0);
        chk("t6_rst_idle", idle_o, 1);
        step();
        req_valid_i = '0; req_store_i = '0;
        rst_ni = 1'b1;
        req_valid_i = 4'b1111; cache_req_ready_i = 1'b1;
        push(0, 1'b0);
        @(negedge clk_i);
        chk("t6_ptr_zero_sid", cache_req_sid_o, 0);
        step();
        push(1, 1'b0);
        step();
        req_valid_i = '0;
        step();
        chk("end_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
